// File: rtl/count_capture_fifo.sv
// ----------------------------------------------------------------------------
// count_capture_fifo
//
// Snapshots values from the 4-bit counter into a small show-ahead FIFO.
// A snapshot is taken on an explicit capture strobe, or automatically when
// the counter wraps from all-ones to zero (if AUTO_WRAP is set). Each entry
// is {wrap_tag, count}. Entries are drained through a valid/ready port.
// When the FIFO is full, extra pushes are dropped. A drop sets a sticky
// overflow flag and increments a saturating drop counter.
//
// Ports
//   clk        rising-edge clock, shared with the counter
//   reset      synchronous, active-high; dominant over all other inputs
//   count_in   live counter value
//   capture    one-cycle request to snapshot count_in
//   clr_ovf    clears overflow and drop_cnt (a same-cycle drop wins)
//   out_ready  reader accepts the head entry this cycle
//   out_valid  FIFO non-empty; head entry presented on out_data
//   out_data   {wrap_tag, count} of the head entry; zero when empty
//   level      number of entries held, 0..DEPTH
//   full       level == DEPTH
//   overflow   sticky flag: at least one push was dropped
//   drop_cnt   number of dropped pushes, saturating at 255
// ----------------------------------------------------------------------------
module count_capture_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter bit AUTO_WRAP = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     capture,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH:0]           out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] prev_count;

    logic             wrap_evt;
    logic             push;
    logic             pop;
    logic             do_write;
    logic             drop;

    // Wrap is seen as the all-ones -> zero transition of the counter.
    // prev_count resets to zero, so a zero count right after reset is not a wrap.
    always_comb begin
        wrap_evt = AUTO_WRAP && (prev_count == {WIDTH{1'b1}}) && (count_in == '0);
        push     = capture | wrap_evt;
        pop      = out_valid & out_ready;
        // When full, a simultaneous pop frees the slot the write lands in.
        do_write = push & (~full | pop);
        drop     = push & full & ~pop;
    end

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage array. Contents need no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {wrap_evt, count_in};
        end
    end

    // Pointers, occupancy and the registered copy of the counter.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            prev_count <= '0;
        end else begin
            prev_count <= count_in;
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_write && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !do_write) begin
                level <= level - LW'(1);
            end
        end
    end

    // Overflow bookkeeping. A drop in the same cycle as clr_ovf takes
    // priority, leaving the flag set and the counter at exactly one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// ----------------------------------------------------------------------------
// tb_count_capture_fifo
//
// Directed bench for count_capture_fifo. A reference queue holds the entries
// the FIFO should contain. Entries are pushed as stimulus is driven, and
// popped and compared when the reader accepts the head. A second instance
// with AUTO_WRAP=0 shares the inputs, so the wrap-disabled behaviour can be
// checked alongside the default one.
// ----------------------------------------------------------------------------
module tb_count_capture_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count_in;
    logic             capture;
    logic             clr_ovf;
    logic             out_ready;

    logic             out_valid;
    logic [WIDTH:0]   out_data;
    logic [3:0]       level;
    logic             full;
    logic             overflow;
    logic [7:0]       drop_cnt;

    logic             out_valid0;
    logic [WIDTH:0]   out_data0;
    logic [3:0]       level0;
    logic             full0;
    logic             overflow0;
    logic [7:0]       drop_cnt0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [WIDTH:0]   refQueue [$];
    logic [WIDTH-1:0] refPrev;
    logic             refOverflow;
    logic [7:0]       refDrop;

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AUTO_WRAP(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .capture   (capture),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AUTO_WRAP(1'b0)) dutNoWrap (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .capture   (capture),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid0),
        .out_data  (out_data0),
        .level     (level0),
        .full      (full0),
        .overflow  (overflow0),
        .drop_cnt  (drop_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by every check in the bench.
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compares every registered output against the reference model.
    task automatic checkOutput(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'(refQueue.size() != 0));
        check({tag, "_data"}, 32'(out_data), (refQueue.size() != 0) ? 32'(refQueue[0]) : 32'd0);
        check({tag, "_level"}, 32'(level), 32'(refQueue.size()));
        check({tag, "_full"}, 32'(full), 32'(refQueue.size() == DEPTH));
        check({tag, "_ovf"}, 32'(overflow), 32'(refOverflow));
        check({tag, "_drop"}, 32'(drop_cnt), 32'(refDrop));
    endtask

    // Drives one cycle of inputs, updates the model for that edge, then
    // checks the outputs just after the edge. The head is compared on pop.
    task automatic applyStimulus(input string tag, input logic cap, input logic [WIDTH-1:0] cnt,
                                 input logic rdy, input logic clr);
        logic           wrap;
        logic           doPush;
        logic           doPop;
        logic [WIDTH:0] expHead;
        capture   = cap;
        count_in  = cnt;
        out_ready = rdy;
        clr_ovf   = clr;
        wrap   = (refPrev == {WIDTH{1'b1}}) && (cnt == '0);
        doPush = cap | wrap;
        doPop  = rdy && (refQueue.size() != 0);
        if (doPop) begin
            expHead = refQueue.pop_front();
            check({tag, "_popdata"}, 32'(out_data), 32'(expHead));
        end
        if (doPush && refQueue.size() < DEPTH) begin
            refQueue.push_back({wrap, cnt});
        end else if (doPush) begin
            refOverflow = 1'b1;
            if (clr) refDrop = 8'd1;
            else if (refDrop != 8'hFF) refDrop = refDrop + 8'd1;
        end else if (clr) begin
            refOverflow = 1'b0;
            refDrop     = 8'd0;
        end
        refPrev = cnt;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Synchronous reset for one edge; inputs other than reset are left as is.
    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        refQueue.delete();
        refPrev     = '0;
        refOverflow = 1'b0;
        refDrop     = 8'd0;
    endtask

    initial begin
        reset     = 1'b1;
        count_in  = '0;
        capture   = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        refPrev     = '0;
        refOverflow = 1'b0;
        refDrop     = 8'd0;
        @(posedge clk);
        doReset();
        checkOutput("reset");

        $display("[TB] capture then pop");
        applyStimulus("t1_cap", 1'b1, 4'd5, 1'b0, 1'b0);
        check("t1_head", 32'(out_data), 32'h05);
        applyStimulus("t1_pop", 1'b0, 4'd5, 1'b1, 1'b0);
        applyStimulus("t1_idle", 1'b0, 4'd5, 1'b0, 1'b0);

        $display("[TB] wrap capture");
        applyStimulus("t2_14", 1'b0, 4'd14, 1'b0, 1'b0);
        applyStimulus("t2_15", 1'b0, 4'd15, 1'b0, 1'b0);
        applyStimulus("t2_0", 1'b0, 4'd0, 1'b0, 1'b0);
        check("t2_wrapword", 32'(out_data), 32'h10);
        check("t2_nowrap_valid", 32'(out_valid0), 32'd0);
        check("t2_nowrap_level", 32'(level0), 32'd0);
        applyStimulus("t2_pop", 1'b0, 4'd0, 1'b1, 1'b0);

        $display("[TB] fill past full");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus("t3_fill", 1'b1, WIDTH'(i), 1'b0, 1'b0);
        end
        check("t3_full", 32'(full), 32'd1);
        check("t3_level", 32'(level), 32'd8);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_dropcnt", 32'(drop_cnt), 32'd2);

        $display("[TB] push and pop while full");
        applyStimulus("t4_both", 1'b1, 4'd11, 1'b1, 1'b0);
        check("t4_level", 32'(level), 32'd8);
        check("t4_dropcnt", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("t4_drain", 1'b0, 4'd11, 1'b1, 1'b0);
        end
        check("t4_empty", 32'(out_valid), 32'd0);

        $display("[TB] saturation and clear");
        for (int i = 0; i < DEPTH + 260; i++) begin
            applyStimulus("t6_sat", 1'b1, 4'd3, 1'b0, 1'b0);
        end
        check("t6_sat", 32'(drop_cnt), 32'd255);
        applyStimulus("t6_clrdrop", 1'b1, 4'd3, 1'b0, 1'b1);
        check("t6_clrdrop_ovf", 32'(overflow), 32'd1);
        check("t6_clrdrop_cnt", 32'(drop_cnt), 32'd1);
        applyStimulus("t6_clr", 1'b0, 4'd3, 1'b0, 1'b1);
        check("t6_clr_ovf", 32'(overflow), 32'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t5_drain", 1'b0, 4'd15, 1'b1, 1'b0);
        end
        check("t5_level5", 32'(level), 32'd5);
        applyStimulus("t5_drop", 1'b1, 4'd15, 1'b0, 1'b0);
        applyStimulus("t5_drop2", 1'b1, 4'd15, 1'b0, 1'b0);
        applyStimulus("t5_drop3", 1'b1, 4'd15, 1'b0, 1'b0);
        applyStimulus("t5_drop4", 1'b1, 4'd15, 1'b0, 1'b0);
        doReset();
        checkOutput("t5_reset");
        applyStimulus("t5_zero", 1'b0, 4'd0, 1'b0, 1'b0);
        check("t5_nowrap", 32'(out_valid), 32'd0);
        applyStimulus("t5_cap", 1'b1, 4'd9, 1'b1, 1'b0);
        applyStimulus("t5_pop", 1'b0, 4'd9, 1'b1, 1'b0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
